memory_responder: RTL and testbench
===================================

# memory_responder

Memory-side responder for the processor's instruction/data bus: serves the fetch (FETCH_MSB_IR/FETCH_LSB_IR), LOAD_STAGE and STORE_STAGE requests issued by the control unit. Holds a DEPTH×MEMORY_DATA_BITS RAM, answers each request with a one-cycle acknowledge after a programmable number of wait states, and supports a two-beat read burst so an instruction's MSB and LSB bytes can be fetched with one request. Widths come from constants_pkg.

## Interface
- ADDR_BITS, default MEMORY_ADDRESS_BITS (8): address width.
- DATA_BITS, default MEMORY_DATA_BITS (8): data width.
- DEPTH, default 256: implemented words; legal range 1..2**ADDR_BITS.
- WAIT_STATES, default 0: extra cycles before each first-beat ack; legal range 0..15.

- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  in  1  request valid, level; held with addr/we/wdata/burst stable until ack.
- mem_we  in  1  1 = write, 0 = read.
- mem_burst  in  1  read only: return bytes at addr and addr+1.
- mem_addr  in  ADDR_BITS  request address.
- mem_wdata  in  DATA_BITS  write data.
- mem_ack  out  1  registered one-cycle pulse per beat.
- mem_rdata  out  DATA_BITS  read data, valid with mem_ack, held until next ack.
- mem_err  out  1  valid with mem_ack: beat address >= DEPTH.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, ACK, ACK2.
- IDLE: on edge with mem_req=1, latch addr/we/wdata/burst (burst forced 0 when we=1); go to WAIT with counter = WAIT_STATES if WAIT_STATES>0, else ACK.
- WAIT: counter decrements each edge; at counter=1 go to ACK.
- Entering ACK (edge): write commits if we=1 and addr<DEPTH; read loads mem_rdata from RAM[addr]; mem_ack←1; mem_err←(addr>=DEPTH).
- ACK: next state ACK2 if latched burst=1, else IDLE. mem_req ignored.
- Entering ACK2: mem_rdata←RAM[(addr+1) mod 2**ADDR_BITS]; mem_err per that address; mem_ack←1. Next state IDLE. No wait states between beats.
- Out-of-range read: mem_rdata←0, mem_err=1. Out-of-range write: RAM untouched, mem_err=1.
- Address wrap: burst at 2**ADDR_BITS−1 reads second beat from address 0.
- Write then read same address in the next request returns new data (no read-before-write hazard; transactions serialized).
- mem_ack/mem_err are 0 in every cycle not in ACK/ACK2.

## Timing
- Reset (async, reset_n=0): state IDLE, mem_ack=0, mem_err=0, mem_rdata=0, busy=0, counter=0. RAM contents not reset, undefined at power-up.
- Reset mid-transaction: aborted immediately; a write not yet committed (reset asserted before the edge entering ACK) is never committed.
- Latency: request sampled at edge E; mem_ack high in cycle after E+WAIT_STATES edges (WAIT_STATES=0: ack in the cycle immediately after sampling edge).
- Throughput: one single-beat transaction per WAIT_STATES+2 cycles; burst occupies WAIT_STATES+3 cycles.
- Requester updates or drops mem_req at the edge ending the (last) ack cycle; a req still high in IDLE is a new transaction.
- Changing request fields while busy=1 has no effect.

## Test plan
- WAIT_STATES=0: write 0xA5 to 0x10, then read 0x10 -> ack one cycle after each sampling edge, rdata=0xA5, err=0, busy high exactly one cycle per transaction.
- WAIT_STATES=3: read 0x10 -> ack exactly 4 cycles after sampling edge, busy high 4 cycles, ack width 1 cycle.
- Burst read at 0xFF after writing 0x12@0xFF, 0x34@0x00 -> two consecutive ack cycles, rdata 0x12 then 0x34.
- DEPTH=128: write 0x77 to 0x90 -> ack with err=1; read 0x90 -> rdata=0x00, err=1; burst at 0x7F -> beat1 err=0, beat2 err=1.
- WAIT_STATES=2: assert write 0x55@0x20 (old 0x11), pull reset_n low one cycle after sampling -> outputs zero immediately, no ack; later read 0x20 -> 0x11.
- Back-to-back: req held high across four reads of 0x00..0x03 -> exactly four acks, none in adjacent cycles, rdata sequence matches written values.

Source files
------------

// File: rtl/memory_responder.sv
// Bus-side RAM responder: serves single-beat reads/writes and two-beat read bursts
// with a one-cycle registered acknowledge after a configurable number of wait states.
package constants_pkg;
  localparam int unsigned MEMORY_ADDRESS_BITS = 8;
  localparam int unsigned MEMORY_DATA_BITS    = 8;
endpackage

module memory_responder
  import constants_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = MEMORY_ADDRESS_BITS,
  parameter int unsigned DATA_BITS   = MEMORY_DATA_BITS,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic                 mem_burst,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic [DATA_BITS-1:0] mem_wdata,
  output logic                 mem_ack,
  output logic [DATA_BITS-1:0] mem_rdata,
  output logic                 mem_err,
  output logic                 busy
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StAck, StAck2} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   wdata_q, wdata_d;
  logic                   we_q, we_d, burst_q, burst_d;
  logic                   ack_q, ack_d, err_q, err_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;

  logic [DATA_BITS-1:0]   mem_q [DEPTH];
  logic [ADDR_BITS-1:0]   cur_addr, beat_addr;
  logic [DATA_BITS-1:0]   cur_wdata, read_val;
  logic [IdxW-1:0]        beat_idx;
  logic                   cur_we, beat_we, in_range, ram_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    burst_d = burst_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          we_d    = mem_we;
          burst_d = mem_burst & ~mem_we;
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = StAck;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAck;
      end
      StAck:   state_d = burst_q ? StAck2 : StIdle;
      StAck2:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // From IDLE with no wait states the beat is served straight from the bus fields.
  always_comb begin
    cur_addr  = (state_q == StIdle) ? mem_addr  : addr_q;
    cur_we    = (state_q == StIdle) ? mem_we    : we_q;
    cur_wdata = (state_q == StIdle) ? mem_wdata : wdata_q;
    beat_addr = (state_q == StAck) ? addr_q + ADDR_BITS'(1) : cur_addr;
    beat_we   = (state_q == StAck) ? 1'b0 : cur_we;
    in_range  = 32'(beat_addr) < DEPTH;
    beat_idx  = beat_addr[IdxW-1:0];
    read_val  = in_range ? mem_q[beat_idx] : '0;
    ack_d     = (state_d == StAck) || (state_d == StAck2);
    err_d     = ack_d & ~in_range;
    rdata_d   = (ack_d && !beat_we) ? read_val : rdata_q;
    // reset_n gate keeps an aborted write from landing on the edge reset releases.
    ram_we    = reset_n & (state_d == StAck) & beat_we & in_range;
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[beat_idx] <= cur_wdata;
  end

  assign mem_ack   = ack_q;
  assign mem_err   = err_q;
  assign mem_rdata = rdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: three instances cover zero, three and two wait
// states, a reduced-depth RAM, bursts with wrap, back-to-back traffic and mid-write reset.
module tb_memory_responder;

  logic       clk = 1'b0;
  logic       rst_n [3];
  logic       req [3], we [3], burst [3];
  logic [7:0] addr [3], wdata [3];
  logic       ack [3], err [3], busy [3];
  logic [7:0] rdata [3];

  int n_checks = 0;
  int n_errors = 0;

  int         t_nack, t_busy, t_lat1, t_lat2;
  logic [7:0] t_rd1, t_rd2;
  logic       t_e1, t_e2;

  always #5 clk = ~clk;

  memory_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset_n(rst_n[0]), .mem_req(req[0]), .mem_we(we[0]), .mem_burst(burst[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_ack(ack[0]), .mem_rdata(rdata[0]),
    .mem_err(err[0]), .busy(busy[0])
  );
  memory_responder #(.DEPTH(128), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]), .mem_req(req[1]), .mem_we(we[1]), .mem_burst(burst[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_ack(ack[1]), .mem_rdata(rdata[1]),
    .mem_err(err[1]), .busy(busy[1])
  );
  memory_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset_n(rst_n[2]), .mem_req(req[2]), .mem_we(we[2]), .mem_burst(burst[2]),
    .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_ack(ack[2]), .mem_rdata(rdata[2]),
    .mem_err(err[2]), .busy(busy[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request on instance d; observes a fixed window and records ack timing/data.
  task automatic txn(input int d, input logic w, input logic b, input logic [7:0] a,
                     input logic [7:0] wd);
    int want;
    want = (b && !w) ? 2 : 1;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; burst[d] = b; addr[d] = a; wdata[d] = wd;
    t_nack = 0; t_busy = 0; t_lat1 = 0; t_lat2 = 0;
    t_rd1 = '0; t_rd2 = '0; t_e1 = 1'b0; t_e2 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (busy[d]) t_busy++;
      if (ack[d]) begin
        t_nack++;
        if (t_nack == 1) begin
          t_lat1 = c; t_rd1 = rdata[d]; t_e1 = err[d];
        end else begin
          t_lat2 = c; t_rd2 = rdata[d]; t_e2 = err[d];
        end
        if (t_nack >= want) req[d] = 1'b0;
      end
    end
    req[d] = 1'b0;
  endtask

  initial begin
    int         nack, adj;
    logic       prev;
    logic [7:0] got [4];

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; burst[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0;
    end
    #12;
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("reset_outs%0d", i), {busy[i], err[i], ack[i], rdata[i]}, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Zero wait states: write then read back
    txn(0, 1'b1, 1'b0, 8'h10, 8'hA5);
    check_eq("w0_wr_lat", t_lat1, 1);
    check_eq("w0_wr_nack", t_nack, 1);
    check_eq("w0_wr_busy", t_busy, 1);
    check_eq("w0_wr_err", t_e1, 0);
    txn(0, 1'b0, 1'b0, 8'h10, 8'h00);
    check_eq("w0_rd_lat", t_lat1, 1);
    check_eq("w0_rd_data", t_rd1, 8'hA5);
    check_eq("w0_rd_busy", t_busy, 1);
    check_eq("w0_rd_err", t_e1, 0);

    // Burst across the top of the address space
    txn(0, 1'b1, 1'b0, 8'hFF, 8'h12);
    txn(0, 1'b1, 1'b0, 8'h00, 8'h34);
    txn(0, 1'b0, 1'b1, 8'hFF, 8'h00);
    check_eq("burst_nack", t_nack, 2);
    check_eq("burst_lat1", t_lat1, 1);
    check_eq("burst_lat2", t_lat2, 2);
    check_eq("burst_rd1", t_rd1, 8'h12);
    check_eq("burst_rd2", t_rd2, 8'h34);
    check_eq("burst_err", {t_e1, t_e2}, 0);
    check_eq("burst_busy", t_busy, 2);

    // A burst flag on a write must be ignored
    txn(0, 1'b1, 1'b1, 8'h40, 8'h9E);
    check_eq("wr_burst_nack", t_nack, 1);

    // Back-to-back reads with req held high
    for (int i = 0; i < 4; i++) txn(0, 1'b1, 1'b0, 8'(i), 8'hC0 + 8'(i));
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; burst[0] = 1'b0; addr[0] = 8'h00;
    nack = 0; adj = 0; prev = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (ack[0]) begin
        if (prev) adj++;
        if (nack < 4) got[nack] = rdata[0];
        nack++;
        addr[0] = 8'(nack);
        if (nack >= 4) req[0] = 1'b0;
      end
      prev = ack[0];
    end
    req[0] = 1'b0;
    check_eq("b2b_nack", nack, 4);
    check_eq("b2b_adjacent", adj, 0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("b2b_data%0d", i), got[i], 8'hC0 + 8'(i));

    // Three wait states, depth 128
    txn(1, 1'b1, 1'b0, 8'h10, 8'h3C);
    check_eq("w3_wr_lat", t_lat1, 4);
    txn(1, 1'b0, 1'b0, 8'h10, 8'h00);
    check_eq("w3_rd_lat", t_lat1, 4);
    check_eq("w3_rd_busy", t_busy, 4);
    check_eq("w3_rd_nack", t_nack, 1);
    check_eq("w3_rd_data", t_rd1, 8'h3C);
    txn(1, 1'b1, 1'b0, 8'h90, 8'h77);
    check_eq("oor_wr_err", t_e1, 1);
    check_eq("oor_wr_nack", t_nack, 1);
    txn(1, 1'b0, 1'b0, 8'h90, 8'h00);
    check_eq("oor_rd_data", t_rd1, 8'h00);
    check_eq("oor_rd_err", t_e1, 1);
    txn(1, 1'b0, 1'b0, 8'h10, 8'h00);
    check_eq("oor_no_alias", t_rd1, 8'h3C);
    txn(1, 1'b1, 1'b0, 8'h7F, 8'h5A);
    txn(1, 1'b0, 1'b1, 8'h7F, 8'h00);
    check_eq("d128_burst_nack", t_nack, 2);
    check_eq("d128_burst_lat2", t_lat2, 5);
    check_eq("d128_beat1", {t_e1, t_rd1}, {1'b0, 8'h5A});
    check_eq("d128_beat2", {t_e2, t_rd2}, {1'b1, 8'h00});

    // Reset during a waiting write on the two-wait-state instance
    txn(2, 1'b1, 1'b0, 8'h20, 8'h11);
    check_eq("w2_wr_lat", t_lat1, 3);
    txn(2, 1'b0, 1'b0, 8'h20, 8'h00);
    check_eq("w2_rd_data", t_rd1, 8'h11);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; burst[2] = 1'b0; addr[2] = 8'h20; wdata[2] = 8'h55;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy_before", busy[2], 1);
    @(posedge clk);
    #1 rst_n[2] = 1'b0;
    #1 check_eq("rst_outs", {busy[2], err[2], ack[2], rdata[2]}, 32'h0);
    nack = 0;
    @(negedge clk);
    req[2] = 1'b0;
    if (ack[2]) nack++;
    @(negedge clk);
    if (ack[2]) nack++;
    rst_n[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack[2] || busy[2]) nack++;
    end
    check_eq("rst_no_ack", nack, 0);
    txn(2, 1'b0, 1'b0, 8'h20, 8'h00);
    check_eq("rst_no_commit", t_rd1, 8'h11);
    check_eq("rst_rd_lat", t_lat1, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
